regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 32-bit MIPS register file's single write port. It accepts write requests from three producers: ALU, load unit and multiply/divide unit. Each producer uses a valid/ready handshake into a one-entry holding register per source. The block grants the port round-robin and drives the register file's write-enable, write-address and write-data from a registered output stage. It also exports a pending-write mask for hazard detection in the decode stage.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid_i  in  1  ALU write request
- alu_addr_i  in  ADDR_W  ALU destination register
- alu_data_i  in  DATA_W  ALU result
- alu_ready_o  out  1  ALU holding register can accept this cycle
- ld_valid_i / ld_addr_i / ld_data_i / ld_ready_o  same as ALU, load unit
- md_valid_i / md_addr_i / md_data_i / md_ready_o  same as ALU, mult/div unit
- wr_en_o  out  1  register file write enable (RegWrite)
- wr_addr_o  out  ADDR_W  register file write address
- wr_data_o  out  DATA_W  register file write data
- busy_o  out  32  bit r = 1 while a write to register r is held or on the port
- grant_o  out  3  one-hot source of current wr_en_o write ({md, ld, alu}); 0 when idle

## Operation
- Source index: ALU=0, LD=1, MD=2.
- Per source: hold_valid, hold_addr, hold_data.
- ready_o[i] = ~hold_valid[i] | gnt[i]. This is combinational and has no dependency on valid_i.
- Accept at the edge where valid_i & ready_o.
  - addr_i != 0: load the holding register.
  - addr_i == 0: the write to $zero is discarded. hold_valid is unchanged, and the entry is cleared if it was granted.
- gnt is combinational and one-hot over hold_valid. Search starts at rr_ptr and goes ALU→LD→MD with wrap. The first valid source wins.
- On an edge with any gnt:
  - wr_en_o←1.
  - wr_addr_o/wr_data_o←granted hold entry.
  - grant_o←gnt.
  - Granted hold_valid clears unless the same edge accepts a new request.
  - rr_ptr←(granted index+1) mod 3.
- On an edge with no gnt: wr_en_o←0, grant_o←0. wr_addr_o/wr_data_o hold their last value. rr_ptr is unchanged.
- busy_o = OR of decode(hold_addr[i]) for valid i, plus decode(wr_addr_o) if wr_en_o. busy_o[0] is always 0.
- Same-cycle requests from different sources to the same register are committed in grant order. The block does no reordering or merging. Decode must use busy_o to avoid ordering hazards.

## Timing
- Reset (async assert, sync deassert by upstream) sets:
  - hold_valid=0, rr_ptr=ALU
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0, grant_o=0
  - busy_o=0, all ready_o=1
- Latency:
  - Request accepted at edge N → eligible for grant in cycle N..N+1.
  - Earliest port drive is after edge N+1.
  - The register file commits at the negedge inside that cycle.
- Throughput: one write per cycle sustained. A source that is granted every cycle can also be accepted every cycle, because ready stays high through the grant.
- Worst-case wait: a held entry is granted within 3 cycles of becoming valid.
- Reset mid-operation: all held requests are dropped and wr_en_o falls immediately. No partial state survives.
- wr_en_o is a one-cycle pulse per write. Back-to-back writes keep it high with changing address/data.

## Test plan
- Reset with all valids high → during reset all outputs 0 and ready_o=3'b111. After release, first edge accepts all three. Next edge grants ALU; wr_en_o=1, grant_o=001.
- ALU r5=0x1111, LD r6=0x2222, MD r7=0x3333 accepted on the same edge → port shows r5, r6, r7 on three consecutive cycles. rr_ptr then points to ALU. busy_o bits 5/6/7 clear one at a time.
- ALU requests every cycle while LD holds r9=0xAAAA → LD is granted within 2 cycles. ALU throughput resumes afterwards. No write is lost (scoreboard compare).
- Request to r0 with data 0xDEADBEEF → accepted (ready=1) and wr_en_o never asserts for it. busy_o stays 0.
- LD holds r3 while MD holds r3 → both writes issue in rr order. busy_o[3] stays 1 until the second write leaves the port, then 0.
- Assert rst_n low while two entries are held and wr_en_o=1 → outputs go to 0 without a clock edge. After release, no stale write appears.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Bus bundle for the register-file write-back arbiter.
//               Carries the three producer valid/ready channels (ALU, load
//               unit, mult/div unit) and the register-file write port with
//               its busy mask and grant vector.
// Ports       : slave  - arbiter side (producer requests in, write port out)
//               master - producer/consumer side (mirror of slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NREG = 1 << ADDR_W;

    // ALU producer
    logic              alu_valid_i;
    logic [ADDR_W-1:0] alu_addr_i;
    logic [DATA_W-1:0] alu_data_i;
    logic              alu_ready_o;
    // Load-unit producer
    logic              ld_valid_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic [DATA_W-1:0] ld_data_i;
    logic              ld_ready_o;
    // Mult/div producer
    logic              md_valid_i;
    logic [ADDR_W-1:0] md_addr_i;
    logic [DATA_W-1:0] md_data_i;
    logic              md_ready_o;
    // Register-file write port and hazard mask
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic [NREG-1:0]   busy_o;
    logic [2:0]        grant_o;

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  ld_valid_i,  ld_addr_i,  ld_data_i,
        input  md_valid_i,  md_addr_i,  md_data_i,
        output alu_ready_o, ld_ready_o, md_ready_o,
        output wr_en_o, wr_addr_o, wr_data_o, busy_o, grant_o
    );

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output ld_valid_i,  ld_addr_i,  ld_data_i,
        output md_valid_i,  md_addr_i,  md_data_i,
        input  alu_ready_o, ld_ready_o, md_ready_o,
        input  wr_en_o, wr_addr_o, wr_data_o, busy_o, grant_o
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin write-back arbiter for the single write port of
//               the MIPS register file. Each producer (ALU=0, LD=1, MD=2)
//               owns a one-entry holding register; one held entry per cycle
//               is granted and moved into a registered write stage.
// Ports       : clk    - system clock, all state on the rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - regfile_wb_arbiter_if.slave: producer valid/addr/
//                        data/ready, wr_en/wr_addr/wr_data, busy mask, grant
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    regfile_wb_arbiter_if.slave    bus
);
    localparam int c_NSRC = 3;
    localparam int c_NREG = 1 << ADDR_W;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LD  = 2'd1,
        SRC_MD  = 2'd2
    } src_e;

    // Producer channels gathered into index-addressable form
    logic [c_NSRC-1:0] src_valid;
    logic [ADDR_W-1:0] src_addr [c_NSRC];
    logic [DATA_W-1:0] src_data [c_NSRC];

    assign src_valid   = {bus.md_valid_i, bus.ld_valid_i, bus.alu_valid_i};
    assign src_addr[0] = bus.alu_addr_i;
    assign src_addr[1] = bus.ld_addr_i;
    assign src_addr[2] = bus.md_addr_i;
    assign src_data[0] = bus.alu_data_i;
    assign src_data[1] = bus.ld_data_i;
    assign src_data[2] = bus.md_data_i;

    // Holding registers
    logic [c_NSRC-1:0] hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_addr_q [c_NSRC];
    logic [ADDR_W-1:0] hold_addr_d [c_NSRC];
    logic [DATA_W-1:0] hold_data_q [c_NSRC];
    logic [DATA_W-1:0] hold_data_d [c_NSRC];

    // Arbitration pointer and registered write stage
    src_e              rr_ptr_q, rr_ptr_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [c_NSRC-1:0] grant_q,   grant_d;

    logic [c_NSRC-1:0] gnt;
    logic [c_NSRC-1:0] ready;
    logic [c_NSRC-1:0] accept;
    logic [c_NREG-1:0] busy;

    // Round-robin search starting at rr_ptr, order ALU -> LD -> MD with wrap.
    always_comb begin
        gnt = '0;
        case (rr_ptr_q)
            SRC_LD: begin
                if      (hold_valid_q[1]) gnt = 3'b010;
                else if (hold_valid_q[2]) gnt = 3'b100;
                else if (hold_valid_q[0]) gnt = 3'b001;
            end
            SRC_MD: begin
                if      (hold_valid_q[2]) gnt = 3'b100;
                else if (hold_valid_q[0]) gnt = 3'b001;
                else if (hold_valid_q[1]) gnt = 3'b010;
            end
            default: begin
                if      (hold_valid_q[0]) gnt = 3'b001;
                else if (hold_valid_q[1]) gnt = 3'b010;
                else if (hold_valid_q[2]) gnt = 3'b100;
            end
        endcase
    end

    // A granted slot empties at this edge, so it can refill in the same
    // cycle; this is what sustains one write per cycle from one source.
    assign ready  = ~hold_valid_q | gnt;
    assign accept = src_valid & ready;

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        for (int i = 0; i < c_NSRC; i++) begin
            if (accept[i] && (src_addr[i] != '0)) begin
                hold_valid_d[i] = 1'b1;
                hold_addr_d[i]  = src_addr[i];
                hold_data_d[i]  = src_data[i];
            end else if (gnt[i]) begin
                // Covers both "granted, nothing new" and "granted while a
                // $zero write is swallowed": the slot ends up empty.
                hold_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        wr_en_d   = 1'b0;
        grant_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rr_ptr_d  = rr_ptr_q;
        for (int i = 0; i < c_NSRC; i++) begin
            if (gnt[i]) begin
                wr_en_d   = 1'b1;
                wr_addr_d = hold_addr_q[i];
                wr_data_d = hold_data_q[i];
                grant_d   = gnt;
            end
        end
        if      (gnt[0]) rr_ptr_d = SRC_LD;
        else if (gnt[1]) rr_ptr_d = SRC_MD;
        else if (gnt[2]) rr_ptr_d = SRC_ALU;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_q <= '0;
            for (int i = 0; i < c_NSRC; i++) begin
                hold_addr_q[i] <= '0;
                hold_data_q[i] <= '0;
            end
            rr_ptr_q  <= SRC_ALU;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            grant_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            grant_q      <= grant_d;
        end
    end

    // Pending-write mask: everything held plus whatever is on the port now.
    always_comb begin
        busy = '0;
        for (int i = 0; i < c_NSRC; i++) begin
            if (hold_valid_q[i]) busy[hold_addr_q[i]] = 1'b1;
        end
        if (wr_en_q) busy[wr_addr_q] = 1'b1;
        busy[0] = 1'b0;
    end

    assign bus.alu_ready_o = ready[0];
    assign bus.ld_ready_o  = ready[1];
    assign bus.md_ready_o  = ready[2];
    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.grant_o     = grant_q;
    assign bus.busy_o      = busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter. Expected
//               writes are queued when stimulus is issued; a negedge monitor
//               pops and compares every write seen on the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [2:0]        grant;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        case (s)
            0: begin bus.alu_valid_i = v; bus.alu_addr_i = a; bus.alu_data_i = d; end
            1: begin bus.ld_valid_i  = v; bus.ld_addr_i  = a; bus.ld_data_i  = d; end
            default: begin bus.md_valid_i = v; bus.md_addr_i = a; bus.md_data_i = d; end
        endcase
    endtask

    task automatic clear_all();
        for (int s = 0; s < 3; s++) set_src(s, 1'b0, '0, '0);
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [2:0] g);
        exp_t e;
        e.addr = a; e.data = d; e.grant = g;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy_o != '0 || bus.wr_en_o) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL %s_drain: %0d writes still pending, busy=0x%08h", name,
                     exp_q.size(), bus.busy_o);
        end
    endtask

    function automatic logic [31:0] rdy();
        return 32'({bus.md_ready_o, bus.ld_ready_o, bus.alu_ready_o});
    endfunction

    // Scoreboard monitor: every write on the port must match the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=0x%08h grant=%03b expected no write",
                         bus.wr_addr_o, bus.wr_data_o, bus.grant_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.wr_addr_o !== e.addr || bus.wr_data_o !== e.data ||
                    bus.grant_o !== e.grant) begin
                    errors++;
                    $display("FAIL wr_port: got addr=%0d data=0x%08h grant=%03b expected addr=%0d data=0x%08h grant=%03b",
                             bus.wr_addr_o, bus.wr_data_o, bus.grant_o,
                             e.addr, e.data, e.grant);
                end
            end
        end
    end

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_all();

        // Reset with all requests asserted
        set_src(0, 1'b1, 5'd1, 32'h0000_0101);
        set_src(1, 1'b1, 5'd2, 32'h0000_0202);
        set_src(2, 1'b1, 5'd3, 32'h0000_0303);
        tick();
        tick();
        chk("rst_wr_en",   32'(bus.wr_en_o),   32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        chk("rst_wr_data", bus.wr_data_o,      32'd0);
        chk("rst_grant",   32'(bus.grant_o),   32'd0);
        chk("rst_busy",    bus.busy_o,         32'd0);
        chk("rst_ready",   rdy(),              32'b111);
        push(5'd1, 32'h0000_0101, 3'b001);
        push(5'd2, 32'h0000_0202, 3'b010);
        push(5'd3, 32'h0000_0303, 3'b100);
        rst_n = 1'b1;
        tick();                                 // accepts all three
        clear_all();
        chk("t1_busy_acc",  bus.busy_o, 32'h0000_000E);
        chk("t1_ready_acc", rdy(),      32'b001);
        tick();
        chk("t1_first_wr_en", 32'(bus.wr_en_o), 32'd1);
        chk("t1_first_grant", 32'(bus.grant_o), 32'b001);
        drain("t1");

        // Three simultaneous requests, busy bits retire one per cycle
        push(5'd5, 32'h0000_1111, 3'b001);
        push(5'd6, 32'h0000_2222, 3'b010);
        push(5'd7, 32'h0000_3333, 3'b100);
        set_src(0, 1'b1, 5'd5, 32'h0000_1111);
        set_src(1, 1'b1, 5'd6, 32'h0000_2222);
        set_src(2, 1'b1, 5'd7, 32'h0000_3333);
        tick();
        clear_all();
        chk("t2_busy_c0", bus.busy_o, 32'h0000_00E0);
        tick();
        chk("t2_busy_c1", bus.busy_o, 32'h0000_00E0);
        tick();
        chk("t2_busy_c2", bus.busy_o, 32'h0000_00C0);
        tick();
        chk("t2_busy_c3", bus.busy_o, 32'h0000_0080);
        tick();
        chk("t2_busy_c4", bus.busy_o, 32'h0000_0000);
        drain("t2");

        // ALU streams while LD holds r9; LD must slip in second
        push(5'd10, 32'h0000_00A0, 3'b001);
        push(5'd9,  32'h0000_AAAA, 3'b010);
        for (int k = 1; k <= 4; k++) push(5'(10 + k), 32'(32'hA0 + k), 3'b001);
        set_src(1, 1'b1, 5'd9,  32'h0000_AAAA);
        set_src(0, 1'b1, 5'd10, 32'h0000_00A0);
        tick();
        set_src(1, 1'b0, '0, '0);
        for (int k = 1; k <= 4; k++) begin
            set_src(0, 1'b1, 5'(10 + k), 32'(32'hA0 + k));
            n = 0;
            while (!bus.alu_ready_o && n < 10) begin
                tick();
                n++;
            end
            if (n >= 10) begin
                checks++;
                errors++;
                $display("FAIL t3_alu_ready_timeout: got ready=0 expected ready=1 within 10 cycles");
            end
            tick();
        end
        clear_all();
        drain("t3");

        // Write to $zero is swallowed
        set_src(0, 1'b1, 5'd0, 32'hDEAD_BEEF);
        chk("t4_ready", 32'(bus.alu_ready_o), 32'd1);
        tick();
        clear_all();
        chk("t4_busy", bus.busy_o, 32'd0);
        chk("t4_not_held", 32'(bus.alu_ready_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_no_wr", 32'(bus.wr_en_o), 32'd0);
        end

        // LD and MD both target r3; rr pointer is at LD after the ALU stream
        push(5'd3, 32'h0000_0033, 3'b010);
        push(5'd3, 32'h0000_0044, 3'b100);
        set_src(1, 1'b1, 5'd3, 32'h0000_0033);
        set_src(2, 1'b1, 5'd3, 32'h0000_0044);
        tick();
        clear_all();
        chk("t5_busy_c0", bus.busy_o, 32'h0000_0008);
        tick();
        chk("t5_busy_c1", bus.busy_o, 32'h0000_0008);
        tick();
        chk("t5_busy_c2", bus.busy_o, 32'h0000_0008);
        tick();
        chk("t5_busy_c3", bus.busy_o, 32'h0000_0000);
        drain("t5");

        // Asynchronous reset while two entries are held and the port is active
        set_src(0, 1'b1, 5'd20, 32'h0000_0020);
        set_src(1, 1'b1, 5'd21, 32'h0000_0021);
        set_src(2, 1'b1, 5'd22, 32'h0000_0022);
        tick();
        clear_all();
        tick();
        chk("t6_pre_wr_en",   32'(bus.wr_en_o),   32'd1);
        chk("t6_pre_wr_addr", 32'(bus.wr_addr_o), 32'd20);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en",   32'(bus.wr_en_o),   32'd0);
        chk("t6_rst_wr_addr", 32'(bus.wr_addr_o), 32'd0);
        chk("t6_rst_wr_data", bus.wr_data_o,      32'd0);
        chk("t6_rst_grant",   32'(bus.grant_o),   32'd0);
        chk("t6_rst_busy",    bus.busy_o,         32'd0);
        chk("t6_rst_ready",   rdy(),              32'b111);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t6_post_wr_en", 32'(bus.wr_en_o), 32'd0);
            chk("t6_post_busy",  bus.busy_o,       32'd0);
        end

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
